sync_ram_ctrl: RTL and testbench
================================

Name: sync_ram_ctrl

Overview:
Parametrised single-port synchronous memory with a clear controller. It supersedes the fixed 16x4 lookup ROM as the team's general on-chip storage block. Adds configurable width/depth, writes, selectable read-during-write mode, optional output register, a read-valid strobe, out-of-range detection, and a hardware clear sequence after reset or on request.

Parameters:
DATA_W, 4, data word width in bits (>=1)
ADDR_W, 4, address width in bits (>=1)
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W
RD_MODE, 0, read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = read latency 1, 1 = extra output register, latency 2
INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequence

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  access enable, sampled at rising edge
we  input  1  write enable, qualified by en
addr  input  ADDR_W  word address
wdata  input  DATA_W  write data
clr  input  1  request a memory re-clear, single-cycle pulse
rdata  output  DATA_W  read data
rvalid  output  1  one-cycle strobe, rdata updated this cycle
err  output  1  one-cycle strobe, out-of-range access
busy  output  1  clear sequence active; accesses ignored

Behaviour:
- Single clock domain; reset is asynchronous and active-low (rst_n), applied immediately, released synchronously by the environment.
- Reset values: rdata = 0, rvalid = 0, err = 0, busy = 1, FSM = CLEAR, clear pointer = 0, output pipeline flushed. The array itself is not reset; only the clear sequence initialises it.
- FSM states:
  - CLEAR: writes INIT_VAL to word ptr each cycle, ptr 0 -> DEPTH-1. After the edge that writes DEPTH-1, go to READY. busy = 1 throughout.
  - READY: busy = 0.
- Clear timing: busy is high for exactly DEPTH rising edges after reset release. The first cycle it reads 0, the next access is accepted.
- In CLEAR: en, we and clr are ignored. No rvalid or err is produced, and rdata holds.
- READY, clr = 1: ptr = 0 and FSM goes to CLEAR at the next edge. clr has priority over en in the same cycle; that access is dropped with no strobe. A read already in the OUT_REG stage still completes and strobes.
- Read (READY, en = 1, we = 0, addr < DEPTH): mem[addr] appears on rdata with rvalid = 1.
  - OUT_REG = 0: after 1 edge.
  - OUT_REG = 1: after 2 edges.
  - Back-to-back reads are fully pipelined, one per cycle.
- Write (READY, en = 1, we = 1, addr < DEPTH): mem[addr] <= wdata at the edge. The access also strobes rvalid with the same latency.
  - RD_MODE = 0: rdata = previous mem[addr].
  - RD_MODE = 1: rdata = wdata.
- Out of range (en = 1, addr >= DEPTH): no write, rdata holds, rvalid = 0. err = 1 for one cycle at the slot where rvalid would have appeared. Cannot occur when DEPTH = 2**ADDR_W.
- Idle (en = 0): rdata holds its last value, rvalid = 0, err = 0.
- rvalid and err are never high together. Each is high for a single cycle per accepted access.
- Reset mid-clear or mid-access: everything returns to reset values and the clear restarts from word 0. Partially completed strobes are discarded.
- Target size: 120-400 lines RTL including the array, FSM and optional output stage.

Test Plan:
1. Defaults; rst_n low 2 cycles, release -> busy = 1 for 16 edges then 0; rvalid stays 0, and reads of any address 0..15 then return 4'h0 with rvalid = 1 one edge later.
2. Write 4'h6 to addr 4'b0011, then read 4'b0011 -> write cycle: rdata = 4'h0 (RD_MODE = 0), rvalid = 1; read: rdata = 4'h6. With RD_MODE = 1 the write cycle returns rdata = 4'h6.
3. en = 0 with addr = 4'b1111 after a read returning 4'h6 -> rdata holds 4'h6, rvalid = 0, no write. Then en = 1, read addr 4'b1000 -> 4'h0.
4. OUT_REG = 1: reads of addrs 3, 0, 3 on consecutive cycles -> rvalid high 3 consecutive cycles starting 2 edges after the first; data 4'h6, 4'h0, 4'h6.
5. DEPTH = 12, read addr 4'hC -> err = 1 one edge later, rvalid = 0, rdata unchanged. A write to 4'hF leaves all words 0..11 unmodified (read back).
6. INIT_VAL = 4'hA, store 4'h5 at addr 2, pulse clr together with a read -> read dropped (no rvalid), busy = 1 for 16 cycles. Afterwards addr 2 reads 4'hA. Asserting rst_n low mid-clear restarts the 16-cycle busy window.

Source files
------------

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with a hardware clear sequencer.
// Read latency is 1 cycle, or 2 cycles when the optional output register is enabled.
module sync_ram_ctrl #(
    parameter int unsigned       DATA_W   = 4,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       RD_MODE  = 0,
    parameter int unsigned       OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   ptr, ptr_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                accept, in_range, last_ptr;
    logic [DATA_W-1:0]   rd_word;
    logic                s1_valid, s1_err;
    logic [DATA_W-1:0]   s1_data;

    assign in_range = 32'(addr) < DEPTH;
    assign accept   = (state == READY) && !clr && en;
    assign last_ptr = (ptr == ADDR_W'(DEPTH - 1));
    assign rd_word  = (RD_MODE == 1 && we) ? wdata : mem[addr];

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                ptr_next = ptr + 1'b1;
                if (last_ptr) begin
                    state_next = READY;
                    ptr_next   = '0;
                end
            end
            READY: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Array is deliberately not reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[ptr] <= INIT_VAL;
        else if (accept && we && in_range)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept && in_range;
            s1_err   <= accept && !in_range;
            if (accept && in_range)
                s1_data <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Second stage keeps shifting during CLEAR so an in-flight read still strobes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    rdata  <= '0;
                end else begin
                    rvalid <= s1_valid;
                    err    <= s1_err;
                    if (s1_valid)
                        rdata <= s1_data;
                end
            end
        end else begin : g_no_out_reg
            assign rvalid = s1_valid;
            assign err    = s1_err;
            assign rdata  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Scoreboard bench for sync_ram_ctrl: one default instance and one with
// DEPTH=12, write-first, output register and non-zero clear value.
module tb_sync_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i    [2];
    logic       we_i    [2];
    logic [3:0] addr_i  [2];
    logic [3:0] wdata_i [2];
    logic       clr_i   [2];
    logic [3:0] rdata_o [2];
    logic       rvalid_o[2];
    logic       err_o   [2];
    logic       busy_o  [2];

    typedef struct {
        int unsigned cyc;
        logic        is_err;
        logic [3:0]  data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [3:0]  mm   [2][16];
    int unsigned left [2];
    logic [3:0]  last [2];
    int unsigned cyc = 0;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sync_ram_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_i[0]), .we(we_i[0]), .addr(addr_i[0]),
        .wdata(wdata_i[0]), .clr(clr_i[0]), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
        .err(err_o[0]), .busy(busy_o[0])
    );

    sync_ram_ctrl #(
        .DATA_W(4), .ADDR_W(4), .DEPTH(12), .RD_MODE(1), .OUT_REG(1), .INIT_VAL(4'hA)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_i[1]), .we(we_i[1]), .addr(addr_i[1]),
        .wdata(wdata_i[1]), .clr(clr_i[1]), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
        .err(err_o[1]), .busy(busy_o[1])
    );

    function automatic int unsigned dep(input int d);
        return (d == 0) ? 16 : 12;
    endfunction
    function automatic int unsigned lat(input int d);
        return (d == 0) ? 0 : 1;
    endfunction
    function automatic logic wfirst(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic [3:0] initv(input int d);
        return (d == 0) ? 4'h0 : 4'hA;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference model: evaluates the bench's own inputs at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                left[d] = dep(d);
                for (int a = 0; a < 16; a++) mm[d][a] = initv(d);
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                if (left[d] > 0) begin
                    left[d]--;
                end else if (clr_i[d]) begin
                    left[d] = dep(d);
                    for (int a = 0; a < 16; a++) mm[d][a] = initv(d);
                end else if (en_i[d]) begin
                    e.cyc = cyc + lat(d);
                    if (32'(addr_i[d]) < dep(d)) begin
                        e.is_err = 1'b0;
                        e.data   = (we_i[d] && wfirst(d)) ? wdata_i[d] : mm[d][addr_i[d]];
                        if (we_i[d]) mm[d][addr_i[d]] = wdata_i[d];
                    end else begin
                        e.is_err = 1'b1;
                        e.data   = 4'h0;
                    end
                    push(d, e);
                end
            end
        end
    end

    task automatic mon(input int d);
        exp_t e;
        logic hit;
        hit = 1'b0;
        if (!rst_n) begin
            check($sformatf("d%0d reset rdata", d), 32'(rdata_o[d]), 32'h0);
            check($sformatf("d%0d reset rvalid", d), 32'(rvalid_o[d]), 32'h0);
            check($sformatf("d%0d reset err", d), 32'(err_o[d]), 32'h0);
            check($sformatf("d%0d reset busy", d), 32'(busy_o[d]), 32'h1);
            last[d] = 4'h0;
            return;
        end
        if (d == 0 && q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); hit = 1'b1; end
        if (d == 1 && q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); hit = 1'b1; end
        if (hit && !e.is_err) begin
            check($sformatf("d%0d rvalid", d), 32'(rvalid_o[d]), 32'h1);
            check($sformatf("d%0d err", d), 32'(err_o[d]), 32'h0);
            check($sformatf("d%0d rdata", d), 32'(rdata_o[d]), 32'(e.data));
            last[d] = e.data;
        end else begin
            check($sformatf("d%0d rvalid", d), 32'(rvalid_o[d]), 32'h0);
            check($sformatf("d%0d err", d), 32'(err_o[d]), hit ? 32'h1 : 32'h0);
            check($sformatf("d%0d rdata hold", d), 32'(rdata_o[d]), 32'(last[d]));
        end
        check($sformatf("d%0d busy", d), 32'(busy_o[d]), (left[d] > 0) ? 32'h1 : 32'h0);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic acc(input int d, input logic e, input logic w, input logic [3:0] a,
                       input logic [3:0] wd, input logic c);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            en_i[k] = 1'b0; we_i[k] = 1'b0; addr_i[k] = 4'h0; wdata_i[k] = 4'h0; clr_i[k] = 1'b0;
        end
        en_i[d] = e; we_i[d] = w; addr_i[d] = a; wdata_i[d] = wd; clr_i[d] = c;
    endtask

    task automatic rd(input int d, input logic [3:0] a);
        acc(d, 1'b1, 1'b0, a, 4'h0, 1'b0);
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [3:0] wd);
        acc(d, 1'b1, 1'b1, a, wd, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) acc(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            en_i[k] = 1'b0; we_i[k] = 1'b0; addr_i[k] = 4'h0; wdata_i[k] = 4'h0; clr_i[k] = 1'b0;
            last[k] = 4'h0;
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(18);

        for (int a = 0; a < 16; a++) rd(0, 4'(a));
        wr(0, 4'h3, 4'h6);
        rd(0, 4'h3);
        acc(0, 1'b0, 1'b1, 4'hF, 4'h9, 1'b0);
        rd(0, 4'hF);
        rd(0, 4'h8);

        wr(1, 4'h3, 4'h6);
        rd(1, 4'h3);
        rd(1, 4'h0);
        rd(1, 4'h3);
        rd(1, 4'hC);
        wr(1, 4'hF, 4'h7);
        for (int a = 0; a < 12; a++) rd(1, 4'(a));

        wr(1, 4'h2, 4'h5);
        rd(1, 4'h2);
        acc(1, 1'b1, 1'b0, 4'h2, 4'h0, 1'b1);
        idle(18);
        rd(1, 4'h2);
        rd(1, 4'h3);
        acc(1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        idle(16);

        wr(0, 4'h5, 4'h9);
        rd(0, 4'h5);
        acc(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        idle(5);
        do_reset(2);
        idle(8);
        do_reset(1);
        idle(18);
        rd(0, 4'h5);
        rd(1, 4'h5);

        for (int i = 0; i < 120; i++) begin
            acc($urandom_range(0, 1), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 40) == 0));
        end
        idle(24);
        for (int a = 0; a < 16; a++) rd(0, 4'(a));
        for (int a = 0; a < 16; a++) rd(1, 4'(a));
        idle(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
